// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// instruction format codes and the location of the branch offset field.
package fetch_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        DECODE,
        ISSUE,
        WAIT_DONE,
        HALT
    } state_e;

    localparam logic [1:0] FMT_REG    = 2'b00;
    localparam logic [1:0] FMT_IMM    = 2'b01;
    localparam logic [1:0] FMT_BRANCH = 2'b10;
    localparam logic [1:0] FMT_HALT   = 2'b11;

    localparam int OFF_MSB = 12;
    localparam int OFF_LSB = 5;
    localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

    function automatic logic signed [OFF_W-1:0] branch_offset(input logic [INSTR_W-1:0] instr);
        return $signed(instr[OFF_MSB:OFF_LSB]);
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Cycle counter that flags expiry when the core has been waited on for
// TIMEOUT-1 consecutive cycles without answering.
module fetch_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;

    // Expiry fires on the cycle whose increment would make the count reach TIMEOUT-1.
    assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 2));

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously on reset low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing stage: fetches 16-bit words, resolves
// branches and halts locally, and hands other instructions to the core.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               run,
    input  logic               done,
    input  logic               branch_res,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic               timeout_err
);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [PC_W-1:0]      addr_q, addr_d;
    logic [INSTR_W-1:0]   fetch_q, fetch_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 terr_q, terr_d;
    logic                 wd_expired;
    logic signed [OFF_W-1:0] off_s;
    logic [PC_W-1:0]      off_ext;

    assign off_s   = branch_offset(fetch_q);
    // Signed size cast sign-extends for wide PCs and truncates for narrow ones.
    assign off_ext = PC_W'(off_s);

    fetch_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == ISSUE),
        .enable_i ((state_q == WAIT_DONE) && !done),
        .expired_o(wd_expired)
    );

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fetch_d = fetch_q;
        instr_d = instr_q;
        terr_d  = terr_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    terr_d  = 1'b0;
                end
            end
            FETCH:    state_d = WAIT_MEM;
            WAIT_MEM: begin
                fetch_d = imem_data;
                state_d = DECODE;
            end
            DECODE: begin
                case (fetch_q[1:0])
                    FMT_HALT: state_d = HALT;
                    FMT_BRANCH: begin
                        pc_d    = branch_res ? (pc_q + PC_W'(1) + off_ext) : (pc_q + PC_W'(1));
                        state_d = FETCH;
                    end
                    default: begin
                        instr_d = fetch_q;
                        state_d = ISSUE;
                    end
                endcase
            end
            ISSUE:    state_d = WAIT_DONE;
            WAIT_DONE: begin
                // A done in the expiry cycle still counts as an answer.
                if (done) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = FETCH;
                end else if (wd_expired) begin
                    terr_d  = 1'b1;
                    state_d = HALT;
                end
            end
            default:  state_d = IDLE;
        endcase
    end

    // The memory address only moves when FETCH is entered.
    assign addr_d = (state_d == FETCH) ? pc_d : addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            fetch_q <= '0;
            instr_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            fetch_q <= fetch_d;
            instr_q <= instr_d;
            terr_q  <= terr_d;
        end
    end

    assign imem_addr   = addr_q;
    assign imem_rd     = (state_q == FETCH);
    assign instruction = instr_q;
    assign run         = (state_q == ISSUE);
    assign pc          = pc_q;
    assign busy        = (state_q != IDLE) && (state_q != HALT);
    assign halted      = (state_q == HALT);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and issued
// instructions are queued per program, and monitors compare them as they occur.
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int TIMEOUT = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [15:0]     imem_data = '0;
    logic [15:0]     instruction;
    logic            run;
    logic            done;
    logic            branch_res = 1'b0;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;
    logic            timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [PC_W-1:0] exp_fetch_q[$];
    logic [15:0]     exp_run_q[$];

    logic [15:0] mem [256];

    int   core_delay = 2;
    int   countdown  = 0;
    logic core_done  = 1'b0;
    logic poke_done  = 1'b0;

    assign done = core_done | poke_done;

    fetch_unit #(
        .PC_W   (PC_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .instruction(instruction),
        .run        (run),
        .done       (done),
        .branch_res (branch_res),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    // Core model: answers done core_delay cycles after run; never if core_delay <= 0.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!reset) begin
            countdown = 0;
        end else begin
            if (countdown > 0) begin
                countdown = countdown - 1;
                if (countdown == 0) core_done = 1'b1;
            end
            if (run && core_delay > 0) countdown = core_delay;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event with value 0x%0h", name, act);
    endtask

    // Fetch monitor
    always @(negedge clk) begin
        if (reset && imem_rd) begin
            if (exp_fetch_q.size() == 0) unexpected("fetch_addr", 32'(imem_addr));
            else check("fetch_addr", 32'(imem_addr), 32'(exp_fetch_q.pop_front()));
        end
    end

    // Issue monitor
    always @(negedge clk) begin
        if (reset && run) begin
            if (exp_run_q.size() == 0) unexpected("run_instr", 32'(instruction));
            else check("run_instr", 32'(instruction), 32'(exp_run_q.pop_front()));
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0003;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(halted), 32'd1);
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (!run && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(run), 32'd1);
    endtask

    task automatic drain(input string name);
        check({name, "_fetch_left"}, 32'(exp_fetch_q.size()), 32'd0);
        check({name, "_run_left"}, 32'(exp_run_q.size()), 32'd0);
        exp_fetch_q.delete();
        exp_run_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pc"}, 32'(pc), 32'd0);
        check({name, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({name, "_imem_rd"}, 32'(imem_rd), 32'd0);
        check({name, "_instruction"}, 32'(instruction), 32'd0);
        check({name, "_run"}, 32'(run), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_halted"}, 32'(halted), 32'd0);
        check({name, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        clear_mem();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // done while IDLE is ignored
        poke_done = 1'b1;
        @(negedge clk);
        poke_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", 32'(busy), 32'd0);
        check("idle_done_rd", 32'(imem_rd), 32'd0);
        check("idle_done_pc", 32'(pc), 32'd0);

        // Test 1: one issued op then halt; fetch-to-issue latency
        clear_mem();
        mem[0] = 16'h2000;
        mem[1] = 16'h0003;
        core_delay = 2;
        branch_res = 1'b0;
        exp_fetch_q.push_back(8'd0);
        exp_fetch_q.push_back(8'd1);
        exp_run_q.push_back(16'h2000);
        pulse_start();
        check("t1_fetch_rd", 32'(imem_rd), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_run_cycle4", 32'(run), 32'd1);
        @(negedge clk);
        check("t1_run_one_cycle", 32'(run), 32'd0);
        wait_halted("t1_halted");
        check("t1_pc", 32'(pc), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_instr_held", 32'(instruction), 32'h2000);
        drain("t1");

        // Test 2: branch at 5 with offset -4 taken -> fetch 2
        clear_mem();
        mem[0] = 16'h0082;
        mem[5] = 16'h1F82;
        branch_res = 1'b1;
        exp_fetch_q.push_back(8'd0);
        exp_fetch_q.push_back(8'd5);
        exp_fetch_q.push_back(8'd2);
        pulse_start();
        wait_halted("t2_halted");
        check("t2_pc", 32'(pc), 32'd2);
        drain("t2");

        // Test 3: same branch not taken -> fetch 6
        clear_mem();
        mem[0] = 16'h0082;
        mem[1] = 16'h1FE2;
        mem[2] = 16'h0F02;
        mem[3] = 16'h1002;
        mem[4] = 16'h0022;
        mem[5] = 16'h1F82;
        branch_res = 1'b0;
        for (int a = 0; a <= 6; a++) exp_fetch_q.push_back(PC_W'(a));
        pulse_start();
        wait_halted("t3_halted");
        check("t3_pc", 32'(pc), 32'd6);
        drain("t3");

        // Test 4: issued op at 255 wraps pc to 0
        clear_mem();
        mem[0]   = 16'h1FC2;
        mem[255] = 16'h1235;
        branch_res = 1'b1;
        core_delay = 2;
        exp_fetch_q.push_back(8'd0);
        exp_fetch_q.push_back(8'd255);
        exp_fetch_q.push_back(8'd0);
        exp_run_q.push_back(16'h1235);
        pulse_start();
        wait_run("t4_run");
        mem[0] = 16'h0003;
        wait_halted("t4_halted");
        check("t4_pc", 32'(pc), 32'd0);
        check("t4_no_err", 32'(timeout_err), 32'd0);
        drain("t4");

        // Test 5: watchdog expiry four cycles after run, then restart
        clear_mem();
        mem[0] = 16'h4440;
        core_delay = -1;
        exp_fetch_q.push_back(8'd0);
        exp_run_q.push_back(16'h4440);
        pulse_start();
        wait_run("t5_run");
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("t5_not_yet_halted", 32'(halted), 32'd0);
            check("t5_busy_waiting", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_timeout_err", 32'(timeout_err), 32'd1);
        check("t5_pc_hold", 32'(pc), 32'd0);
        drain("t5a");
        core_delay = 2;
        exp_fetch_q.push_back(8'd0);
        exp_fetch_q.push_back(8'd1);
        exp_run_q.push_back(16'h4440);
        pulse_start();
        check("t5_err_cleared", 32'(timeout_err), 32'd0);
        check("t5_refetch_addr", 32'(imem_addr), 32'd0);
        wait_halted("t5_rehalted");
        check("t5_pc_after", 32'(pc), 32'd1);
        check("t5_err_after", 32'(timeout_err), 32'd0);
        drain("t5b");

        // Test 6: asynchronous reset during WAIT_DONE
        clear_mem();
        mem[0]  = 16'h0122;
        mem[10] = 16'h0011;
        branch_res = 1'b1;
        core_delay = -1;
        exp_fetch_q.push_back(8'd0);
        exp_fetch_q.push_back(8'd10);
        exp_run_q.push_back(16'h0011);
        pulse_start();
        wait_run("t6_run");
        @(negedge clk);
        check("t6_busy_before", 32'(busy), 32'd1);
        check("t6_pc_before", 32'(pc), 32'd10);
        check("t6_instr_before", 32'(instruction), 32'h0011);
        reset = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        drain("t6a");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_idle_after", 32'(busy), 32'd0);
        mem[0] = 16'h0003;
        exp_fetch_q.push_back(8'd0);
        pulse_start();
        check("t6_restart_addr", 32'(imem_addr), 32'd0);
        wait_halted("t6_halted");
        check("t6_pc", 32'(pc), 32'd0);
        drain("t6b");

        // Test 7: start in WAIT_DONE ignored; done in expiry cycle wins
        clear_mem();
        mem[0] = 16'h0042;
        mem[3] = 16'h1230;
        branch_res = 1'b1;
        core_delay = 3;
        exp_fetch_q.push_back(8'd0);
        exp_fetch_q.push_back(8'd3);
        exp_fetch_q.push_back(8'd4);
        exp_run_q.push_back(16'h1230);
        pulse_start();
        wait_run("t7_run");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t7_busy", 32'(busy), 32'd1);
        check("t7_pc", 32'(pc), 32'd3);
        check("t7_no_refetch", 32'(imem_rd), 32'd0);
        check("t7_not_halted", 32'(halted), 32'd0);
        wait_halted("t7_halted");
        check("t7_pc_final", 32'(pc), 32'd4);
        check("t7_done_wins", 32'(timeout_err), 32'd0);
        drain("t7");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and sequencing stage directly upstream of the processor core. Holds the program counter, reads 16-bit instructions from a synchronous instruction memory, resolves branch and halt formats locally, and hands every remaining instruction to the core with a one-cycle `run` pulse. It waits for the core's `done` before advancing. A watchdog halts the sequence if the core never answers.

## Interface
- `PC_W`, 8: program counter and memory address width; PC wraps modulo 2^PC_W.
- `TIMEOUT`, 64: maximum cycles spent in WAIT_DONE before error halt; must be ≥ 2.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low. Low forces all state to reset values immediately.
- `start` in 1: begin execution at PC 0. Honoured only in IDLE or HALT.
- `imem_addr` out PC_W: instruction memory address, equal to `pc` during FETCH.
- `imem_rd` out 1: memory read strobe. `imem_data` is valid exactly one cycle later.
- `imem_data` in 16: instruction word from memory.
- `instruction` out 16: instruction presented to the core, held stable from ISSUE until the next ISSUE.
- `run` out 1: one-cycle pulse telling the core to execute `instruction`.
- `done` in 1: core completion, sampled only in WAIT_DONE.
- `branch_res` in 1: core condition flag, sampled in DECODE for branch instructions.
- `pc` out PC_W: current program counter.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `timeout_err` out 1: sticky; set by a watchdog expiry, cleared by `start` or reset.

## Operation
- Format field is `instruction[1:0]`:
  - 00 register op: issued to the core.
  - 01 immediate op: issued to the core.
  - 10 branch: consumed here, never issued.
  - 11 halt: consumed here, never issued.
- Branch offset is `imem_data[12:5]` as signed 8-bit, sign-extended or truncated to PC_W.
  - Taken (`branch_res`=1): next pc = pc + 1 + offset.
  - Not taken: next pc = pc + 1.
  - All PC arithmetic wraps modulo 2^PC_W, with no error.
- States and transitions:
  - IDLE: `start` → FETCH, with pc ← 0 and `timeout_err` ← 0.
  - FETCH: `imem_rd`=1, `imem_addr`=pc; always → WAIT_MEM.
  - WAIT_MEM: latch `imem_data` into the internal fetch register; → DECODE.
  - DECODE:
    - format 11 → HALT, pc unchanged.
    - format 10 → update pc, then FETCH.
    - otherwise `instruction` ← fetch register → ISSUE.
  - ISSUE: `run`=1 for this cycle only; watchdog counter ← 0; → WAIT_DONE.
  - WAIT_DONE:
    - `done`=1 → pc ← pc+1, FETCH.
    - Otherwise counter increments; counter reaching TIMEOUT−1 with no `done` → HALT with `timeout_err` ← 1.
    - `done` and expiry in the same cycle: `done` wins.
  - HALT: `start` → FETCH, with pc ← 0 and `timeout_err` ← 0. All other inputs are ignored.
- `start` in any state other than IDLE or HALT is ignored.
- `done` outside WAIT_DONE is ignored. A `done` arriving in the ISSUE cycle is lost; the core must not assert it that early.

## Timing
- Reset values:
  - pc=0, imem_addr=0, imem_rd=0, instruction=0, run=0, busy=0, halted=0, timeout_err=0.
  - State = IDLE.
- Reset asserted mid-operation: outputs return to reset values asynchronously. A `run` pulse in progress is cut off.
- Fetch-to-issue latency: `start` sampled at edge 0 → FETCH at cycle 1, WAIT_MEM at 2, DECODE at 3, `run` high in cycle 4.
- Back-to-back non-branch instructions: `done` sampled at edge n → next `run` at cycle n+4.
- Branch costs 3 cycles (FETCH, WAIT_MEM, DECODE) and emits no `run`.
- `imem_addr` is registered; it changes only on entry to FETCH.

## Structure
- Package `fetch_pkg` holds:
  - The state enum: IDLE, FETCH, WAIT_MEM, DECODE, ISSUE, WAIT_DONE, HALT.
  - Format constants FMT_REG=2'b00, FMT_IMM=2'b01, FMT_BRANCH=2'b10, FMT_HALT=2'b11.
  - The offset field bounds.
- One sub-module, `fetch_watchdog`: a counter with clear, enable, and expiry output, parameterised by TIMEOUT.
- FSM, PC update and output registers stay in `fetch_unit`.

## Test plan
- Memory [0]=16'h2000, [1]=16'h0003. `start`; core returns `done` 2 cycles after `run`.
  - → exactly one `run` with `instruction`=16'h2000, then HALT with pc=1, `halted`=1.
- Branch at address 5 with offset 8'hFC and format 10, `branch_res`=1.
  - → next fetch `imem_addr`=2, and no `run` for the branch.
  - Same with `branch_res`=0 → `imem_addr`=6.
- PC_W=8, pc=255 holding a non-branch instruction; `done` returned.
  - → next `imem_addr`=0, no error.
- TIMEOUT=4, core never asserts `done`.
  - → HALT with `timeout_err`=1 four cycles after `run`. A following `start` clears `timeout_err` and refetches address 0.
- Pull `reset` low while in WAIT_DONE.
  - → all outputs at reset values in the same cycle.
  - After release, `start` restarts from pc=0.
- `start` pulsed during WAIT_DONE, and `done` pulsed during IDLE.
  - → both ignored; state and pc unchanged.
